// File: rtl/fifo_defs.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_defs;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2, used to size pointers from DEPTH at elaboration time.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage array: synchronous write, registered or asynchronous read.
module fifo_dpram
    import fifo_defs::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH),
    parameter int MODE   = MODE_STD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (MODE == MODE_FWFT) begin : g_async
            // Read strobe and reset are not needed when the head is shown combinationally.
            wire unused_ok = &{1'b0, rst, rd_en};
            assign rd_data = mem[rd_addr];
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            logic [DATA_W-1:0] rd_data_d;

            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_en) begin
                    rd_data_d = mem[rd_addr];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional FWFT output, occupancy count,
// almost-full/almost-empty flags and one-cycle overflow/underflow pulses.
module sync_fifo_param
    import fifo_defs::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = MODE_STD,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_req,
    input  logic [DATA_W-1:0] FIFO_write_data,
    input  logic              read_req,
    output logic [DATA_W-1:0] FIFO_read_data,
    output logic              full_sig,
    output logic              empty_sig,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] ram_rd_data;

    // A write into a full FIFO is still taken when a pop frees the slot on the same edge.
    always_comb begin
        wr_ok    = write_req & (~full_q | read_req);
        rd_ok    = read_req & ~empty_q;
        wr_ptr_d = wr_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        af_d     = (count_d >= AF_C);
        ae_d     = (count_d <= AE_C);
        ovf_d    = write_req & ~wr_ok;
        unf_d    = read_req & empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .MODE   (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (FIFO_write_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Last popped word, presented while the FIFO is empty.
            logic [DATA_W-1:0] hold_q, hold_d;

            always_comb begin
                hold_d = hold_q;
                if (rd_ok) begin
                    hold_d = ram_rd_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign FIFO_read_data = empty_q ? hold_q : ram_rd_data;
        end else begin : g_std
            assign FIFO_read_data = ram_rd_data;
        end
    endgenerate

    assign full_sig     = full_q;
    assign empty_sig    = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances driven in lockstep against a queue model.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              write_req = 1'b0;
    logic              read_req = 1'b0;
    logic [DATA_W-1:0] wdata = '0;

    logic [DATA_W-1:0] rdata_s, rdata_f;
    logic              full_s, full_f, empty_s, empty_f;
    logic              af_s, af_f, ae_s, ae_f;
    logic              ovf_s, ovf_f, unf_s, unf_f;
    logic [CNT_W-1:0]  count_s, count_f;

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .write_req(write_req), .FIFO_write_data(wdata),
        .read_req(read_req), .FIFO_read_data(rdata_s), .full_sig(full_s), .empty_sig(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .write_req(write_req), .FIFO_write_data(wdata),
        .read_req(read_req), .FIFO_read_data(rdata_f), .full_sig(full_f), .empty_sig(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: contents as a queue plus the last word handed out.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_std;
    logic [DATA_W-1:0] m_hold;
    bit                m_ovf;
    bit                m_unf;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  d;
        int          cnt;
        bit          emp;
        bit          unf;
        logic [7:0]  rdat;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] pk(input logic [CNT_W-1:0] c, input logic f, input logic e,
                                       input logic a_f, input logic a_e, input logic o,
                                       input logic u, input logic [7:0] d);
        return {c, f, e, a_f, a_e, o, u, d};
    endfunction

    task automatic check_model(input string tag);
        int n;
        logic [7:0] fexp;
        n = q.size();
        fexp = (n > 0) ? q[0] : m_hold;
        check({tag, " std"}, 32'(pk(count_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s, rdata_s)),
              32'(pk(CNT_W'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, m_std)));
        check({tag, " fwft"}, 32'(pk(count_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f, rdata_f)),
              32'(pk(CNT_W'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, fexp)));
    endtask

    task automatic step(input bit wr, input bit rd, input logic [7:0] d, input string tag);
        int n0;
        bit wok, rok;
        write_req = wr;
        read_req  = rd;
        wdata     = d;
        @(posedge clk);
        n0  = q.size();
        wok = wr && (n0 < DEPTH || rd);
        rok = rd && (n0 > 0);
        if (rok) begin
            m_std  = q.pop_front();
            m_hold = m_std;
        end
        if (wok) q.push_back(d);
        m_ovf = wr && !wok;
        m_unf = rd && (n0 == 0);
        #1;
        write_req = 1'b0;
        read_req  = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        write_req = 1'b0;
        read_req  = 1'b0;
        @(posedge clk);
        q.delete();
        m_std  = '0;
        m_hold = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        #1;
        rst = 1'b0;
        check_model("reset");
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h05, 1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'h06, 1, 1'b0, 1'b0, 8'h05};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h06};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h06};
        tbl[5] = '{1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b1, 8'h06};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h77};

        do_reset();
        check("reset empty", 32'(empty_s), 32'd1);
        check("reset almost_empty", 32'(ae_s), 32'd1);
        check("reset read data", 32'(rdata_s), 32'd0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].d, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d count", i), 32'(count_s), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d empty", i), 32'(empty_s), 32'(tbl[i].emp));
            check($sformatf("tbl%0d underflow", i), 32'(unf_s), 32'(tbl[i].unf));
            check($sformatf("tbl%0d rdata", i), 32'(rdata_s), 32'(tbl[i].rdat));
        end

        // Fill to full, overflow, full read+write, then drain with wrap.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), "fill");
            if (i == AF - 1) check("af below level", 32'(af_s), 32'd0);
            if (i == AF) check("af at level", 32'(af_s), 32'd1);
        end
        check("full after fill", 32'(full_s), 32'd1);
        step(1'b1, 1'b0, 8'hEE, "overflow");
        check("overflow pulse", 32'(ovf_s), 32'd1);
        check("overflow count held", 32'(count_s), 32'd16);
        step(1'b0, 1'b0, 8'h00, "idle");
        check("overflow clears", 32'(ovf_s), 32'd0);
        step(1'b1, 1'b1, 8'hAA, "full rw");
        check("full rw count", 32'(count_s), 32'd16);
        check("full rw full", 32'(full_s), 32'd1);
        check("full rw data", 32'(rdata_s), 32'h01);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check($sformatf("drain%0d data", i), 32'(rdata_s), (i < DEPTH - 1) ? 32'(i + 2) : 32'hAA);
        end
        check("drained empty", 32'(empty_s), 32'd1);

        // FWFT: write into empty appears without a read.
        do_reset();
        step(1'b1, 1'b0, 8'h33, "fwft write");
        check("fwft head shown", 32'(rdata_f), 32'h33);
        check("fwft not empty", 32'(empty_f), 32'd0);
        step(1'b0, 1'b1, 8'h00, "fwft pop");
        check("fwft empty after pop", 32'(empty_f), 32'd1);
        check("fwft holds popped", 32'(rdata_f), 32'h33);

        // Reset in the middle of filling discards everything.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "midfill");
        check("midfill count", 32'(count_s), 32'd9);
        do_reset();
        check("post reset count", 32'(count_s), 32'd0);
        check("post reset empty", 32'(empty_s), 32'd1);
        check("post reset almost_empty", 32'(ae_s), 32'd1);
        step(1'b1, 1'b0, 8'h5C, "new write");
        step(1'b0, 1'b1, 8'h00, "new read");
        check("new data std", 32'(rdata_s), 32'h5C);
        check("new data fwft", 32'(rdata_f), 32'h5C);

        // Randomised traffic with phases biased toward full, empty and balanced.
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 150) % 3)
                0: begin pw = 80; pr = 30; end
                1: begin pw = 25; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     8'($urandom_range(0, 255)), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 8-bit `fifo_module`.
- Generalised in data width and depth.
- Adds:
  - selectable first-word-fall-through (FWFT) read mode;
  - programmable almost-full and almost-empty flags;
  - an occupancy count;
  - one-cycle overflow and underflow error pulses.
- Single-clock buffer between producer and consumer state machines in the same clock domain.

Parameters:
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- write_req, in, 1: write request.
- FIFO_write_data, in, DATA_W: write data, sampled with write_req.
- read_req, in, 1: read (pop) request.
- FIFO_read_data, out, DATA_W: read data.
- full_sig, out, 1: FIFO holds DEPTH entries.
- empty_sig, out, 1: FIFO holds 0 entries.
- almost_full, out, 1: count ≥ AF_LEVEL.
- almost_empty, out, 1: count ≤ AE_LEVEL.
- count, out, ADDR_W+1: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse; write rejected because full.
- underflow, out, 1: one-cycle pulse; read rejected because empty.

Behaviour:
- Reset (rst high at posedge):
  - pointers = 0, count = 0;
  - empty_sig = 1, full_sig = 0;
  - almost_empty = 1; almost_full = 0 (AF_LEVEL ≥ 1);
  - overflow = 0, underflow = 0;
  - FIFO_read_data = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; first post-reset cycle behaves as empty.
- Acceptance rules:
  - wr_ok = write_req & (!full_sig | read_req).
  - rd_ok = read_req & !empty_sig.
- Full boundary:
  - Full with read and write in the same cycle: both accepted; count unchanged, full_sig stays 1.
  - Full with write only: write dropped; overflow = 1 next cycle; state unchanged.
- Empty boundary:
  - Empty with read and write in the same cycle: write accepted, read rejected.
  - underflow = 1 next cycle; count becomes 1.
  - Empty with read only: underflow = 1; FIFO_read_data unchanged.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 → 0 naturally.
  - count += wr_ok - rd_ok.
- Flags:
  - All flags and count are registered and updated on the same edge as the pointers; they reflect post-operation state.
  - No combinational path from request inputs to flags.
- Standard mode (FWFT=0):
  - Accepted read → FIFO_read_data = mem[rd_ptr] on the next posedge (1-cycle latency).
  - Otherwise FIFO_read_data holds its value.
- FWFT mode (FWFT=1):
  - FIFO_read_data shows the head entry whenever empty_sig = 0.
  - read_req acknowledges and pops it.
  - A write into an empty FIFO appears on FIFO_read_data, with empty_sig = 0, one cycle after the write edge.
  - While empty, FIFO_read_data holds the last popped value.
- Memory: write-first not required. The read address is never equal to the write address of an accepted write unless the FIFO is full, and in that case the read uses old data (read-before-write).

Decomposition:
- Shared package/header `fifo_defs`:
  - clog2 function;
  - ADDR_W = clog2(DEPTH);
  - FWFT mode constants (MODE_STD = 0, MODE_FWFT = 1).
- One sub-module, `fifo_dpram`: simple dual-port array (DEPTH × DATA_W) with synchronous write port and read port.
  - FWFT=0: registered read.
  - FWFT=1: asynchronous read.
- The top holds pointers, count, flags and error pulses.

Test Plan:
- Reset, then write 5, idle, then write 6 with read → standard mode returns 5 one cycle after the read; count sequence 1, 1, 1; then read → 6, empty_sig = 1.
- Fill DEPTH=16 with 0x01..0x10 → full_sig = 1 after 16th write; almost_full = 1 at count 14; 17th write gives overflow pulse; drain returns 0x01..0x10 in order.
- Read on empty → underflow pulse, FIFO_read_data unchanged; simultaneous read+write on empty → count = 1, underflow = 1.
- Full with simultaneous read+write of 0xAA → count stays 16; 0xAA emerges after 16 further reads; pointers wrap correctly.
- FWFT=1: write 0x33 into empty → FIFO_read_data = 0x33, empty_sig = 0 next cycle, with no read_req; read_req pops it → empty_sig = 1.
- Assert rst mid-fill at count 9 → next cycle count = 0, empty_sig = 1, almost_empty = 1; next write/read returns the new data only.
